accum_serial_tx: RTL and testbench
==================================

# accum_serial_tx

Parallel-to-serial transmitter that takes a 16-bit accumulator value and drives it out on a single line as a framed serial word. It sits downstream of the accumulator register and forms the read side of it. The accumulator captures ALU results. This block takes a captured value through a load/ready handshake and sends it off-chip MSB-first with start, even-parity and stop bits.

## Interface
- `DATA_W`, 16: payload width in bits; fixed at 16 for the ALU datapath.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; legal range ≥ 1.

- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `D`  in  16  word to transmit, normally the accumulator Q; sampled only on an accepted load.
- `load`  in  1  request to send `D`.
- `ready`  out  1  high when a load will be accepted (IDLE only).
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in flight (`busy` = !`ready`).
- `done`  out  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- Reset values: `tx`=1, `ready`=1, `busy`=0, `done`=0, state IDLE, shift register 0, bit counter 0, tick counter 0.
- Handshake: a load is accepted on a posedge where `load`&&`ready`. At that edge `D` is copied into the shift register and even parity (XOR of all 16 bits) is latched.
- While busy, `load` is ignored and `D` may change freely.
- FSM states and transitions:
  - IDLE → START on an accepted load.
  - START (`tx`=0) → DATA after `CLKS_PER_BIT` cycles.
  - DATA (`tx`=shift[15], MSB first; shift left by 1 every `CLKS_PER_BIT` cycles) → PARITY after 16 bits.
  - PARITY (`tx`=latched parity) → STOP after `CLKS_PER_BIT` cycles.
  - STOP (`tx`=1) → IDLE after `CLKS_PER_BIT` cycles.
- `done`=1 exactly in the last cycle of STOP; 0 otherwise.
- Tick counter counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary. Bit counter counts 0..15 in DATA only and is cleared on entering DATA.
- Parity rule: the parity bit is chosen so that payload plus parity together hold an even number of 1s.
- Reset mid-frame: `tx` returns high and `ready` returns high immediately (asynchronous), and the frame is abandoned. No `done` pulse is produced.
- Load held continuously: a new frame starts on the first cycle `ready` is high after the previous one. Back-to-back frames are separated by zero idle bit-times beyond the stop bit.

## Timing
- Frame length: 19 × `CLKS_PER_BIT` cycles (1 start, 16 data, 1 parity, 1 stop).
- Acceptance edge = E0. `tx` goes low in the cycle after E0.
- Data bit k (k=0 is D[15]) is driven during cycles `CLKS_PER_BIT`×(1+k)+1 … `CLKS_PER_BIT`×(2+k) after E0.
- `done` is high in cycle 19×`CLKS_PER_BIT` after E0. `ready` rises at the following edge.
- Earliest next acceptance is edge E0 + 19×`CLKS_PER_BIT` + 1.
- All outputs are registered; no combinational path from `load` or `D` to any output.

## Structure
- Shared package `accum_pkg`:
  - state enum {IDLE, START, DATA, PARITY, STOP}
  - `DATA_W`
  - `FRAME_BITS`=19
  - `TX_IDLE`=1'b1
- Sub-module `bit_timer`: tick counter parameterised by `CLKS_PER_BIT`. It has `clk`, `rst` and a `clr` input (asserted on acceptance), and outputs a `tick` pulse at each bit boundary.
- FSM, shift register, parity latch and bit counter stay in the top module.

## Test plan
- Reset then idle 20 cycles → `tx`=1, `ready`=1, `busy`=0, `done`=0 throughout.
- `D`=16'hA5C3, one-cycle `load`, `CLKS_PER_BIT`=4 → sampled line reads 0, 1010_0101_1100_0011, parity 0, stop 1. `done` is pulsed in cycle 76 after acceptance; `ready` returns at cycle 77.
- `D`=16'h0001 → parity bit 1. `D`=16'hFFFF → parity bit 0. `D`=16'h0000 → data bits all 0, parity 0.
- `load` held high with `D` changing every cycle across two frames → second frame carries the `D` present at the edge where `ready`=1. No words are dropped or duplicated, and no idle gap beyond stop.
- `rst` pulsed in the middle of DATA (e.g. cycle 30) → `tx`=1 and `ready`=1 asynchronously, with no `done`. The next load transmits a complete, correct frame.
- `CLKS_PER_BIT`=1, `D`=16'h8001 → 19-cycle frame. `tx` sequence is 0,1,0×14,1,0,1 and `done` is high in cycle 19.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator serial transmitter.
package accum_pkg;

  localparam int DATA_W     = 16;
  localparam int FRAME_BITS = 19;      // start + 16 data + parity + stop
  localparam logic TX_IDLE  = 1'b1;    // line level when nothing is being sent

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage : accum_pkg

// File: rtl/bit_timer.sv
// Free-running tick counter that marks serial bit boundaries. The counter
// restarts from zero when a frame is accepted so the first bit is full length.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count 0..CLKS_PER_BIT-1, wrapping at each bit boundary or on clear.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_cnt <= '0;
    else if (clr || tick)  r_cnt <= '0;
    else                   r_cnt <= r_cnt + CNT_W'(1);
  end

  assign tick = (r_cnt == LAST);

endmodule : bit_timer

// File: rtl/accum_serial_tx.sv
// Framed serial transmitter for the accumulator value: start bit, 16 data
// bits MSB first, even parity, stop bit. Outputs decode only registered state.
module accum_serial_tx
  import accum_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] D,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              w_tick;
  logic              w_accept;
  logic              w_last_bit;

  assign w_accept   = load && (r_state == IDLE);
  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .tick (w_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: each non-idle state lasts one bit time, DATA lasts 16.
  // NOTE: every always_comb output gets a default first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)              w_state_next = START;
      START:   if (w_tick)                w_state_next = DATA;
      DATA:    if (w_tick && w_last_bit)  w_state_next = PARITY;
      PARITY:  if (w_tick)                w_state_next = STOP;
      STOP:    if (w_tick)                w_state_next = IDLE;
      default:                            w_state_next = IDLE;
    endcase
  end

  // Output decode from registered state, shift register and tick counter.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b1;
    tx    = TX_IDLE;
    done  = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      START:   tx   = 1'b0;
      DATA:    tx   = r_shift[DATA_W-1];
      PARITY:  tx   = r_parity;
      STOP:    done = w_tick;
      default: ;
    endcase
  end

  // Payload capture and MSB-first shifting; parity is fixed at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_shift  <= D;
      r_parity <= ^D;
    end else if (r_state == DATA && w_tick) begin
      r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
    end
  end

  // Data bit counter: cleared on entering DATA, advances once per data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_bit_cnt <= '0;
    else if (r_state == START && w_tick)  r_bit_cnt <= '0;
    else if (r_state == DATA && w_tick)   r_bit_cnt <= r_bit_cnt + BIT_W'(1);
  end

endmodule : accum_serial_tx

// File: tb/tb_accum_serial_tx.sv
// Directed bench for accum_serial_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_accum_serial_tx;

  logic        clk = 1'b0;
  logic        rst4, load4, ready4, tx4, busy4, done4;
  logic [15:0] d4;
  logic        rst1, load1, ready1, tx1, busy1, done1;
  logic [15:0] d1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  accum_serial_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst4), .D(d4), .load(load4),
    .ready(ready4), .tx(tx4), .busy(busy4), .done(done4)
  );

  accum_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst1), .D(d1), .load(load1),
    .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready4(input string tag);
    int t = 0;
    while (ready4 !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    check(tag, {31'd0, ready4}, 32'd1);
  endtask

  // Send one word on the CPB=4 instance and check every cycle of the frame.
  task automatic run4(input string tag, input logic [15:0] d, input logic [18:0] exp_frame);
    logic [18:0] frame;
    int          bad;
    int          done_n;
    int          done_at;
    int          b;
    frame   = '0;
    bad     = 0;
    done_n  = 0;
    done_at = 0;
    wait_ready4({tag, "_ready_wait"});
    d4    = d;
    load4 = 1'b1;
    step();                       // acceptance edge E0, now in cycle 1
    load4 = 1'b0;
    d4    = ~d;                   // D is don't-care while busy
    for (int n = 1; n <= 76; n++) begin
      b = (n - 1) / 4;
      if (tx4 !== exp_frame[18-b]) bad++;
      if (ready4 !== 1'b0 || busy4 !== 1'b1) bad++;
      if (n % 4 == 2) frame[18-b] = tx4;
      if (done4 === 1'b1) begin
        done_n++;
        done_at = n;
      end
      if (n < 76) step();
    end
    check({tag, "_frame"},   {13'd0, frame}, {13'd0, exp_frame});
    check({tag, "_cycles"},  bad,     0);
    check({tag, "_done_at"}, done_at, 76);
    check({tag, "_done_n"},  done_n,  1);
    step();                       // cycle 77
    check({tag, "_ready77"}, {30'd0, ready4, busy4}, 32'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          bad;
    int          done_n;
    logic        rec_tx   [0:159];
    logic        rec_done [0:159];
    logic [18:0] f1, f2, seq;
    int          done_at;

    rst4 = 1'b1; load4 = 1'b0; d4 = 16'h0;
    rst1 = 1'b1; load1 = 1'b0; d1 = 16'h0;
    #12;
    check("reset_outputs", {28'd0, tx4, ready4, busy4, done4}, 32'b1100);
    @(negedge clk);
    rst4 = 1'b0;
    rst1 = 1'b0;

    // Idle for 20 cycles: line high, ready, nothing in flight.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({tx4, ready4, busy4, done4} !== 4'b1100) bad++;
    end
    check("idle_20", bad, 0);

    run4("a5c3", 16'hA5C3, {1'b0, 16'hA5C3, 1'b0, 1'b1});
    run4("0001", 16'h0001, {1'b0, 16'h0001, 1'b1, 1'b1});
    run4("ffff", 16'hFFFF, {1'b0, 16'hFFFF, 1'b0, 1'b1});
    run4("0000", 16'h0000, {1'b0, 16'h0000, 1'b0, 1'b1});

    // Load held high with D changing every cycle: second frame takes D at E0+77.
    wait_ready4("b2b_ready_wait");
    d4    = 16'h5B00;
    load4 = 1'b1;
    for (int c = 0; c <= 154; c++) begin
      step();
      rec_tx[c]   = tx4;
      rec_done[c] = done4;
      d4 = 16'h5B00 | 16'(c + 1);
      if (c == 153) load4 = 1'b0;
    end
    for (int b = 0; b < 19; b++) begin
      f1[18-b] = rec_tx[4*b + 1];
      f2[18-b] = rec_tx[77 + 4*b + 1];
    end
    done_n = 0;
    for (int c = 0; c <= 154; c++) if (rec_done[c] === 1'b1) done_n++;
    check("b2b_frame1", {13'd0, f1}, {13'd0, 1'b0, 16'h5B00, 1'b1, 1'b1});
    check("b2b_frame2", {13'd0, f2}, {13'd0, 1'b0, 16'h5B4D, 1'b1, 1'b1});
    check("b2b_gap",    {30'd0, rec_tx[76], rec_tx[77]}, 32'b10);
    check("b2b_done",   {30'd0, rec_done[75], rec_done[152]}, 32'b11);
    check("b2b_done_n", done_n, 2);
    check("b2b_no_third", {31'd0, rec_tx[154]}, 32'd1);

    // Reset in the middle of DATA (cycle 30, inside data bit 6 of 0x0000).
    wait_ready4("rst_ready_wait");
    d4    = 16'h0000;
    load4 = 1'b1;
    step();
    load4 = 1'b0;
    repeat (29) step();
    check("rst_pre_tx", {31'd0, tx4}, 32'd0);
    #2;
    rst4 = 1'b1;
    #1;
    check("rst_async", {28'd0, tx4, ready4, busy4, done4}, 32'b1100);
    @(negedge clk);
    rst4 = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (done4 !== 1'b0 || tx4 !== 1'b1) bad++;
    end
    check("rst_abandoned", bad, 0);
    run4("after_rst", 16'h0001, {1'b0, 16'h0001, 1'b1, 1'b1});

    // Single-clock bit time: 19-cycle frame for 0x8001.
    d1    = 16'h8001;
    load1 = 1'b1;
    step();
    load1 = 1'b0;
    seq     = '0;
    done_n  = 0;
    done_at = 0;
    for (int n = 1; n <= 19; n++) begin
      seq[19-n] = tx1;
      if (done1 === 1'b1) begin
        done_n++;
        done_at = n;
      end
      if (n < 19) step();
    end
    check("cpb1_seq",     {13'd0, seq}, {13'd0, 19'b0_1000000000000001_0_1});
    check("cpb1_done_at", done_at, 19);
    check("cpb1_done_n",  done_n, 1);
    step();
    check("cpb1_ready20", {30'd0, ready1, busy1}, 32'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_accum_serial_tx
